// File: rtl/branch_target_ras_if.sv
// branch_target_ras_if: request/result bundle between decode, target stage and PC-select
interface branch_target_ras_if #(
    parameter int XLEN      = 32,
    parameter int RAS_DEPTH = 4
);
    logic                         flush;
    logic                         valid_in;
    logic [1:0]                   op;
    logic [XLEN-1:0]              pc;
    logic [XLEN-1:0]              rs1;
    logic [XLEN-1:0]              i_typ;
    logic [XLEN-1:0]              b_typ;
    logic [XLEN-1:0]              j_typ;
    logic                         rd_link;
    logic                         rs1_link;
    logic                         valid_out;
    logic [XLEN-1:0]              target;
    logic                         misaligned;
    logic [XLEN-1:0]              ras_pred;
    logic                         ras_pred_valid;
    logic [$clog2(RAS_DEPTH):0]   ras_count;
    logic                         ras_full;
    logic                         ras_empty;

    modport master (
        output flush, valid_in, op, pc, rs1, i_typ, b_typ, j_typ, rd_link, rs1_link,
        input  valid_out, target, misaligned, ras_pred, ras_pred_valid, ras_count, ras_full, ras_empty
    );

    modport slave (
        input  flush, valid_in, op, pc, rs1, i_typ, b_typ, j_typ, rd_link, rs1_link,
        output valid_out, target, misaligned, ras_pred, ras_pred_valid, ras_count, ras_full, ras_empty
    );
endinterface

// File: rtl/branch_target_ras.sv
// branch_target_ras: registered branch/jump target adder with return-address stack
module branch_target_ras #(
    parameter int XLEN        = 32,
    parameter int RAS_DEPTH   = 4,
    parameter int ALIGN_BYTES = 4
) (
    input logic clk,
    input logic rst,
    branch_target_ras_if.slave bus
);
    localparam int PW = $clog2(RAS_DEPTH);
    localparam int CW = PW + 1;

    logic [XLEN-1:0] mem [RAS_DEPTH];
    logic [PW-1:0]   sp;
    logic [PW-1:0]   top;
    logic [CW-1:0]   cnt;
    logic [XLEN-1:0] tgt;
    logic [XLEN-1:0] link;
    logic            mis;
    logic            act;
    logic            push;
    logic            pop;
    logic            hit;

    // target arithmetic, alignment check and stack action decode
    always_comb begin
        tgt  = bus.op == 2'd1 ? bus.pc + bus.b_typ :
               bus.op == 2'd2 ? bus.pc + bus.j_typ :
               (bus.rs1 + bus.i_typ) & ~XLEN'(1);
        mis  = (ALIGN_BYTES == 4) && tgt[1];
        act  = bus.valid_in && !bus.flush && bus.op != 2'd0 && !mis;
        push = act && bus.op[1] && bus.rd_link;
        pop  = act && bus.op == 2'd3 && bus.rs1_link;
        hit  = pop && cnt != '0;
        top  = sp - PW'(1);
        link = bus.pc + XLEN'(4);
    end

    // result registers and stack pointer/count; sp wraps so a full push overwrites the oldest entry
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.valid_out      <= 1'b0;
            bus.target         <= '0;
            bus.misaligned     <= 1'b0;
            bus.ras_pred       <= '0;
            bus.ras_pred_valid <= 1'b0;
            cnt                <= '0;
            sp                 <= '0;
        end else if (bus.flush) begin
            bus.valid_out      <= 1'b0;
            bus.ras_pred       <= '0;
            bus.ras_pred_valid <= 1'b0;
            cnt                <= '0;
            sp                 <= '0;
        end else begin
            bus.valid_out      <= bus.valid_in && bus.op != 2'd0;
            bus.target         <= tgt;
            bus.misaligned     <= mis;
            bus.ras_pred       <= hit ? mem[top] : '0;
            bus.ras_pred_valid <= hit;
            if (push && !hit) begin
                sp  <= sp + PW'(1);
                cnt <= cnt == CW'(RAS_DEPTH) ? cnt : cnt + CW'(1);
            end else if (hit && !push) begin
                sp  <= top;
                cnt <= cnt - CW'(1);
            end
        end
    end

    // stack storage; pop-then-push replaces the top in place
    always_ff @(posedge clk) begin
        if (!rst && push) mem[hit ? top : sp] <= link;
    end

    assign bus.ras_count = cnt;
    assign bus.ras_full  = cnt == CW'(RAS_DEPTH);
    assign bus.ras_empty = cnt == '0;
endmodule

// File: doc/branch_target_ras.md
Name: branch_target_ras

Overview:
- Parametrised successor to the combinational branch/jump target adder used by the OTTER datapath.
- Computes BRANCH/JAL/JALR targets in a registered stage (one-cycle latency), clears JALR bit 0 per RV32I, and flags misaligned targets.
- Maintains a return-address stack (RAS) that supplies a predicted return target for JALR returns.
- Sits between decode/immediate-gen and the PC-select mux.

Parameters:
- XLEN, 32, datapath and address width.
- RAS_DEPTH, 4, number of RAS entries; power of two, 2..16.
- ALIGN_BYTES, 4, required target alignment (4 = no C extension, 2 = C extension); only 2 and 4 legal.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  pipeline flush; clears RAS and pending output.
- valid_in  in  1  request valid this cycle.
- op  in  2  0=NONE, 1=BRANCH, 2=JAL, 3=JALR.
- pc  in  XLEN  instruction PC.
- rs1  in  XLEN  rs1 register value (JALR base).
- i_typ  in  XLEN  sign-extended I-immediate.
- b_typ  in  XLEN  sign-extended B-immediate.
- j_typ  in  XLEN  sign-extended J-immediate.
- rd_link  in  1  rd is x1 or x5.
- rs1_link  in  1  rs1 is x1 or x5.
- valid_out  out  1  registered result valid.
- target  out  XLEN  computed target.
- misaligned  out  1  target violates ALIGN_BYTES.
- ras_pred  out  XLEN  predicted return address (valid only with ras_pred_valid).
- ras_pred_valid  out  1  a RAS pop produced ras_pred.
- ras_count  out  $clog2(RAS_DEPTH)+1  live RAS entries.
- ras_full  out  1  ras_count == RAS_DEPTH.
- ras_empty  out  1  ras_count == 0.

Behaviour:
- Reset (rst=1 at edge): valid_out, target, misaligned, ras_pred, ras_pred_valid, ras_count = 0; ras_empty=1; ras_full=0; RAS storage contents don't-care. rst has priority over flush and valid_in.
- Latency: inputs sampled at edge N; results are visible after edge N and held until the next edge. Each cycle with valid_in=1 and op!=NONE yields valid_out=1 next cycle; otherwise valid_out=0 next cycle.

Target arithmetic (modulo 2^XLEN, wrap silently):
- BRANCH: pc + b_typ.
- JAL: pc + j_typ.
- JALR: (rs1 + i_typ) with bit 0 forced to 0.

Misaligned:
- ALIGN_BYTES=4: misaligned = target[1].
- ALIGN_BYTES=2: misaligned = 0, since JALR bit 0 is already cleared and BRANCH/JAL immediates are even.

RAS actions, only when valid_in=1, flush=0 and the computed target is aligned:
- push (JAL or JALR with rd_link=1): write pc+4 at top; count = min(count+1, RAS_DEPTH).
- pop (JALR with rs1_link=1, rd_link=0): ras_pred = top entry, ras_pred_valid=1, count-1.
- pop-then-push (JALR with rd_link=1 and rs1_link=1): ras_pred = old top, ras_pred_valid=1; top replaced with pc+4; count unchanged.
- Misaligned target: no RAS update; ras_pred_valid=0.

RAS boundary cases:
- Push when full: circular overwrite of the oldest entry; count stays RAS_DEPTH; the newest-RAS_DEPTH entries remain poppable.
- Pop when empty: ras_pred_valid=0, ras_pred=0, count stays 0; target is still produced normally.
- Pop-then-push when empty: ras_pred_valid=0; push occurs, count becomes 1.
- ras_pred_valid=0 and ras_pred=0 on every cycle with no pop.

Flush:
- flush=1 at an edge: count=0, valid_out=0, ras_pred_valid=0 next cycle.
- A concurrent valid_in is dropped and does not push.

Test Plan:
- Reset then idle: rst=1 for 2 cycles -> all outputs 0, ras_empty=1; valid_in=0 -> valid_out stays 0.
- BRANCH pc=0x100, b_typ=0xFFFFFFF8 -> next cycle target=0x0F8, valid_out=1, misaligned=0, ras_count=0; JAL pc=0xFFFFFFFC, j_typ=0x8 -> target=0x4 (wrap).
- JALR rs1=0x2003, i_typ=0x2, rd_link=0, rs1_link=0, ALIGN_BYTES=4 -> target=0x2004 (bit0 cleared), misaligned=0; rs1=0x2001, i_typ=0x1 -> target=0x2002, misaligned=1, no RAS change.
- Call/return: JAL pc=0x40 rd_link=1 -> ras_count=1; JALR rs1_link=1 rd_link=0 -> ras_pred=0x44, ras_pred_valid=1, ras_count=0; second return -> ras_pred_valid=0, ras_pred=0.
- Overflow (RAS_DEPTH=4): 5 calls from pc=0x10,0x20,0x30,0x40,0x50 -> ras_full=1, count=4; 4 pops return 0x54,0x44,0x34,0x24; 5th pop ras_pred_valid=0.
- Coroutine and flush: 2 pushes, then JALR rd_link=rs1_link=1 at pc=0x80 -> ras_pred=old top, count=2, new top 0x84. flush concurrent with a valid JAL -> valid_out=0, count=0, no push. rst asserted mid-stream -> all outputs cleared next cycle.
